// File: rtl/si_pkg.sv
// Shared types and default widths for the simple-interface (si) protocol.
package si_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } si_resp_state_t;

    localparam int SI_ADDR_W = 32;
    localparam int SI_DATA_W = 32;

endpackage

// File: rtl/si_regfile.sv
// DEPTH x DATA_W word array: async reset to INIT_VALUE, one sync write port,
// one combinational read port.
module si_regfile
    import si_pkg::*;
#(
    parameter int                DEPTH      = 16,
    parameter int                DATA_W     = SI_DATA_W,
    parameter int                IDX_W      = 4,
    parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wen,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= INIT_VALUE;
            end
        end else if (wen) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/si_responder.sv
// Target-side si endpoint: latches a request, waits WAIT_CYCLES, then performs
// the read/write against a local register array and pulses fin for one cycle.
module si_responder
    import si_pkg::*;
#(
    parameter int                ADDR_W      = SI_ADDR_W,
    parameter int                DATA_W      = SI_DATA_W,
    parameter int                DEPTH       = 16,
    parameter int                WAIT_CYCLES = 0,
    parameter logic [DATA_W-1:0] INIT_VALUE  = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              exec,
    input  logic              we,
    input  logic [ADDR_W-1:0] si_address,
    input  logic [DATA_W-1:0] si_data,
    output logic [DATA_W-1:0] si_rdata,
    output logic              fin,
    output logic              err,
    output logic              busy
);

    localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

    si_resp_state_t    state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              wen;
    logic              in_range;
    logic [DATA_W-1:0] rf_rdata;

    // Full-width compare: high address bits must not alias into the array.
    assign in_range = ({1'b0, addr_q} < DEPTH_X);

    si_regfile #(
        .DEPTH      (DEPTH),
        .DATA_W     (DATA_W),
        .IDX_W      (IDX_W),
        .INIT_VALUE (INIT_VALUE)
    ) u_regfile (
        .clk   (clk),
        .reset (reset),
        .wen   (wen),
        .waddr (addr_q[IDX_W-1:0]),
        .wdata (data_q),
        .raddr (addr_q[IDX_W-1:0]),
        .rdata (rf_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        data_d  = data_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        wen     = 1'b0;
        case (state_q)
            IDLE: begin
                if (exec) begin
                    we_d    = we;
                    addr_d  = si_address;
                    data_d  = si_data;
                    // Loading WAIT_CYCLES (not -1) lands the response edge
                    // exactly WAIT_CYCLES+1 edges after acceptance.
                    cnt_d   = 8'(WAIT_CYCLES);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 8'd0) begin
                    state_d = RESP;
                    err_d   = ~in_range;
                    wen     = we_q & in_range;
                    rdata_d = (~we_q & in_range) ? rf_rdata : '0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
                rdata_d = '0;
                err_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    assign fin      = (state_q == RESP);
    assign busy     = (state_q != IDLE);
    assign err      = err_q;
    assign si_rdata = rdata_q;

endmodule

// File: tb/tb_si_responder.sv
// Directed bench for si_responder: one instance with no wait states, one with three.
module tb_si_responder;

    localparam logic [31:0] INIT = 32'hC0DE_0000;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        exec  [2];
    logic        we    [2];
    logic [31:0] addr  [2];
    logic [31:0] data  [2];
    logic [31:0] rdata [2];
    logic        fin   [2];
    logic        err   [2];
    logic        busy  [2];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    si_responder #(
        .ADDR_W(32), .DATA_W(32), .DEPTH(16), .WAIT_CYCLES(0), .INIT_VALUE(INIT)
    ) u_dut0 (
        .clk(clk), .reset(reset), .exec(exec[0]), .we(we[0]),
        .si_address(addr[0]), .si_data(data[0]), .si_rdata(rdata[0]),
        .fin(fin[0]), .err(err[0]), .busy(busy[0])
    );

    si_responder #(
        .ADDR_W(32), .DATA_W(32), .DEPTH(16), .WAIT_CYCLES(3), .INIT_VALUE(INIT)
    ) u_dut3 (
        .clk(clk), .reset(reset), .exec(exec[1]), .we(we[1]),
        .si_address(addr[1]), .si_data(data[1]), .si_rdata(rdata[1]),
        .fin(fin[1]), .err(err[1]), .busy(busy[1])
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One request on instance d; returns read data, err and edges from accept to fin.
    task automatic txn(input int d, input logic w, input logic [31:0] a, input logic [31:0] dv,
                       output logic [31:0] rd, output logic e, output int lat);
        exec[d] = 1'b1;
        we[d]   = w;
        addr[d] = a;
        data[d] = dv;
        step();
        exec[d] = 1'b0;
        lat = 0;
        while (fin[d] !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
        if (lat >= 20) chk("fin_timeout", {31'd0, fin[d]}, 32'd1);
        rd = rdata[d];
        e  = err[d];
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        e;
        int          lat;
        int          mask;
        int          nfin;

        for (int i = 0; i < 2; i++) begin
            exec[i] = 1'b0;
            we[i]   = 1'b0;
            addr[i] = '0;
            data[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("rst_fin0",   {31'd0, fin[0]},  32'd0);
        chk("rst_busy0",  {31'd0, busy[0]}, 32'd0);
        chk("rst_err0",   {31'd0, err[0]},  32'd0);
        chk("rst_rdata0", rdata[0],         32'd0);
        chk("rst_busy3",  {31'd0, busy[1]}, 32'd0);
        reset = 1'b0;
        step();

        // WAIT_CYCLES=0: write addr 0, walk the handshake cycle by cycle
        exec[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'd0; data[0] = 32'hB4B4_B4B4;
        step();
        exec[0] = 1'b0;
        chk("w0_busy_acc", {31'd0, busy[0]}, 32'd1);
        chk("w0_fin_acc",  {31'd0, fin[0]},  32'd0);
        step();
        chk("w0_fin",   {31'd0, fin[0]},  32'd1);
        chk("w0_err",   {31'd0, err[0]},  32'd0);
        chk("w0_busy",  {31'd0, busy[0]}, 32'd1);
        chk("w0_rdata", rdata[0],         32'd0);
        step();
        chk("w0_fin_end",  {31'd0, fin[0]},  32'd0);
        chk("w0_busy_end", {31'd0, busy[0]}, 32'd0);

        txn(0, 1'b0, 32'd0, 32'd0, rd, e, lat);
        chk("r0_data", rd, 32'hB4B4_B4B4);
        chk("r0_err",  {31'd0, e}, 32'd0);
        chk("r0_lat",  lat, 32'd1);
        txn(0, 1'b0, 32'd5, 32'd0, rd, e, lat);
        chk("r5_init", rd, INIT);

        // out-of-range writes: exactly DEPTH, and a high-bit address that must not alias
        txn(0, 1'b1, 32'd16, 32'hDEAD_BEEF, rd, e, lat);
        chk("w16_err",   {31'd0, e}, 32'd1);
        chk("w16_rdata", rd, 32'd0);
        txn(0, 1'b1, 32'h0001_0003, 32'h1111_1111, rd, e, lat);
        chk("whi_err", {31'd0, e}, 32'd1);
        txn(0, 1'b0, 32'd0, 32'd0, rd, e, lat);
        chk("r0_after_oor", rd, 32'hB4B4_B4B4);
        txn(0, 1'b0, 32'd3, 32'd0, rd, e, lat);
        chk("r3_after_oor", rd, INIT);
        txn(0, 1'b0, 32'd20, 32'd0, rd, e, lat);
        chk("r20_err",   {31'd0, e}, 32'd1);
        chk("r20_rdata", rd, 32'd0);

        // exec held high for 10 edges: fins expected after edges 2, 5, 8
        exec[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'd4; data[0] = 32'h0000_00F4;
        mask = 0;
        nfin = 0;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (fin[0] === 1'b1) begin
                mask = mask | (1 << (k - 1));
                nfin++;
            end
        end
        exec[0] = 1'b0;
        chk("stream_mask", mask, 32'h0000_0092);
        chk("stream_cnt",  nfin, 32'd3);
        repeat (3) step();

        // WAIT_CYCLES=3
        txn(1, 1'b1, 32'd3, 32'h3333_3333, rd, e, lat);
        chk("d3_w3_lat", lat, 32'd4);
        chk("d3_w3_err", {31'd0, e}, 32'd0);

        exec[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'd2; data[1] = 32'h1234_5678;
        step();
        exec[1] = 1'b0; we[1] = 1'b0; addr[1] = 32'd3; data[1] = 32'hFFFF_FFFF;
        step();
        chk("d3_fin_e1", {31'd0, fin[1]}, 32'd0);
        exec[1] = 1'b1; addr[1] = 32'd7; data[1] = 32'd0;
        step();
        chk("d3_fin_e2",  {31'd0, fin[1]},  32'd0);
        chk("d3_busy_e2", {31'd0, busy[1]}, 32'd1);
        exec[1] = 1'b0;
        step();
        chk("d3_fin_e3", {31'd0, fin[1]}, 32'd0);
        step();
        chk("d3_fin_e4", {31'd0, fin[1]}, 32'd1);
        chk("d3_err_e4", {31'd0, err[1]}, 32'd0);
        step();
        chk("d3_fin_e5",  {31'd0, fin[1]},  32'd0);
        chk("d3_busy_e5", {31'd0, busy[1]}, 32'd0);
        txn(1, 1'b0, 32'd2, 32'd0, rd, e, lat);
        chk("d3_r2", rd, 32'h1234_5678);
        txn(1, 1'b0, 32'd3, 32'd0, rd, e, lat);
        chk("d3_r3", rd, 32'h3333_3333);
        txn(1, 1'b0, 32'd7, 32'd0, rd, e, lat);
        chk("d3_r7", rd, INIT);

        // async reset in the middle of WAIT aborts the write
        exec[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'd1; data[1] = 32'hA5A5_A5A5;
        step();
        exec[1] = 1'b0;
        step();
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_busy",  {31'd0, busy[1]}, 32'd0);
        chk("rst_mid_fin",   {31'd0, fin[1]},  32'd0);
        chk("rst_mid_err",   {31'd0, err[1]},  32'd0);
        chk("rst_mid_rdata", rdata[1],         32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step();
        chk("post_rst_fin", {31'd0, fin[1]}, 32'd0);
        txn(1, 1'b0, 32'd1, 32'd0, rd, e, lat);
        chk("post_rst_r1", rd, INIT);
        txn(1, 1'b0, 32'd2, 32'd0, rd, e, lat);
        chk("post_rst_r2", rd, INIT);
        txn(1, 1'b1, 32'd1, 32'hCAFE_F00D, rd, e, lat);
        chk("post_rst_wlat", lat, 32'd4);
        txn(1, 1'b0, 32'd1, 32'd0, rd, e, lat);
        chk("post_rst_r1w", rd, 32'hCAFE_F00D);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
